// File: rtl/reg_file_pkg.sv
// Shared ARM constants for the banked register file.
// Contains the CPSR mode encodings, the CPSR field geometry, the physical layout and the SPSR bank selector.
package reg_file_pkg;

  // CPSR field positions
  localparam int unsigned CPSR_M_LSB = 0;
  localparam int unsigned CPSR_M_W   = 5;

  // CPSR[4:0] mode encodings
  typedef enum logic [CPSR_M_W-1:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } arm_mode_e;

  // Physical register array geometry
  localparam int unsigned NUM_REGS = 30;
  localparam int unsigned PHYS_W   = 5;
  localparam int unsigned NUM_SPSR = 5;
  localparam int unsigned SPSR_W   = 3;

  // Physical layout:
  //   0-7    r0-r7 shared
  //   8-12   usr r8-r12
  //   13-17  fiq r8-r12
  //   18-29  r13/r14 pairs for usr, fiq, irq, svc, abt, und
  localparam logic [PHYS_W-1:0] PHYS_USR_HI   = 5'd8;
  localparam logic [PHYS_W-1:0] PHYS_FIQ_HI   = 5'd13;
  localparam logic [PHYS_W-1:0] PHYS_USR_SPLR = 5'd18;
  localparam logic [PHYS_W-1:0] PHYS_FIQ_SPLR = 5'd20;
  localparam logic [PHYS_W-1:0] PHYS_IRQ_SPLR = 5'd22;
  localparam logic [PHYS_W-1:0] PHYS_SVC_SPLR = 5'd24;
  localparam logic [PHYS_W-1:0] PHYS_ABT_SPLR = 5'd26;
  localparam logic [PHYS_W-1:0] PHYS_UND_SPLR = 5'd28;

  typedef enum logic [SPSR_W-1:0] {
    SPSR_FIQ = 3'd0,
    SPSR_IRQ = 3'd1,
    SPSR_SVC = 3'd2,
    SPSR_ABT = 3'd3,
    SPSR_UND = 3'd4
  } spsr_bank_e;

  typedef struct packed {
    logic              valid;
    logic [SPSR_W-1:0] idx;
  } spsr_sel_t;

  // Select the SPSR bank for a mode; usr, sys and unknown modes have no SPSR
  function automatic spsr_sel_t spsr_sel(input logic [CPSR_M_W-1:0] mode);
    spsr_sel_t s;
    s = '0;
    case (mode)
      MODE_FIQ: s = '{valid: 1'b1, idx: SPSR_FIQ};
      MODE_IRQ: s = '{valid: 1'b1, idx: SPSR_IRQ};
      MODE_SVC: s = '{valid: 1'b1, idx: SPSR_SVC};
      MODE_ABT: s = '{valid: 1'b1, idx: SPSR_ABT};
      MODE_UND: s = '{valid: 1'b1, idx: SPSR_UND};
      default:  s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_bank_map.sv
// Maps an (architectural index, CPSR mode) pair to a physical register slot.
// hit_o is asserted when the access is real: the port is enabled and the index is not r15.
// When DROP_BAD_MODE is set, an unrecognised mode also kills hit_o; this is the write behaviour.
module reg_bank_map
  import reg_file_pkg::*;
#(
  parameter bit DROP_BAD_MODE = 1'b0
) (
  input  logic                en_i,
  input  logic [3:0]          idx_i,
  input  logic [CPSR_M_W-1:0] mode_i,
  output logic [PHYS_W-1:0]   phys_o,
  output logic                hit_o
);

  logic              mode_ok;
  logic              fiq_bank;
  logic [PHYS_W-1:0] splr_base;

  // Decode mode to bank bases, then place the index inside the bank
  always_comb begin
    mode_ok   = 1'b1;
    fiq_bank  = 1'b0;
    splr_base = PHYS_USR_SPLR;
    case (mode_i)
      MODE_USR, MODE_SYS: splr_base = PHYS_USR_SPLR;
      MODE_FIQ: begin
        fiq_bank  = 1'b1;
        splr_base = PHYS_FIQ_SPLR;
      end
      MODE_IRQ: splr_base = PHYS_IRQ_SPLR;
      MODE_SVC: splr_base = PHYS_SVC_SPLR;
      MODE_ABT: splr_base = PHYS_ABT_SPLR;
      MODE_UND: splr_base = PHYS_UND_SPLR;
      default:  mode_ok   = 1'b0;
    endcase

    phys_o = '0;
    if (idx_i < 4'd8) begin
      phys_o = PHYS_W'(idx_i);
    end else if (idx_i < 4'd13) begin
      phys_o = (fiq_bank ? PHYS_FIQ_HI : PHYS_USR_HI) + PHYS_W'(idx_i - 4'd8);
    end else if (idx_i == 4'd13) begin
      phys_o = splr_base;
    end else if (idx_i == 4'd14) begin
      phys_o = splr_base + 5'd1;
    end

    hit_o = en_i && (idx_i != 4'd15) && (mode_ok || !DROP_BAD_MODE);
  end

endmodule

// File: rtl/reg_file.sv
// Banked ARM register file.
// Provides three combinational read ports and two write ports with same-cycle bypass, plus a banked SPSR with byte-lane writes.
module reg_file
  import reg_file_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          read_0,
  input  logic [3:0]          read_1,
  input  logic [3:0]          read_2,
  output logic [31:0]         rdata_0,
  output logic [31:0]         rdata_1,
  output logic [31:0]         rdata_2,
  input  logic [CPSR_M_W-1:0] rd_mode,
  input  logic                wr0_en,
  input  logic [3:0]          wr0_idx,
  input  logic [31:0]         wr0_data,
  input  logic [CPSR_M_W-1:0] wr0_mode,
  input  logic                wr1_en,
  input  logic [3:0]          wr1_idx,
  input  logic [31:0]         wr1_data,
  input  logic [CPSR_M_W-1:0] wr1_mode,
  output logic [31:0]         spsr_out,
  input  logic [3:0]          spsr_we,
  input  logic [31:0]         spsr_wdata,
  input  logic [CPSR_M_W-1:0] spsr_wmode
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] spsr_q [NUM_SPSR];

  logic [3:0]        rd_idx  [3];
  logic [PHYS_W-1:0] rd_phys [3];
  logic              rd_hit  [3];
  logic [31:0]       rd_data [3];

  logic [PHYS_W-1:0] w0_phys, w1_phys;
  logic              w0_hit, w1_hit, w1_eff;

  spsr_sel_t   wsel, rsel;
  logic        spsr_wr_en;
  logic [31:0] spsr_merged_d;

  assign rd_idx[0] = read_0;
  assign rd_idx[1] = read_1;
  assign rd_idx[2] = read_2;

  for (genvar g = 0; g < 3; g++) begin : g_rd_map
    reg_bank_map #(.DROP_BAD_MODE(1'b0)) u_map (
      .en_i   (1'b1),
      .idx_i  (rd_idx[g]),
      .mode_i (rd_mode),
      .phys_o (rd_phys[g]),
      .hit_o  (rd_hit[g])
    );
  end

  reg_bank_map #(.DROP_BAD_MODE(1'b1)) u_map_wr0 (
    .en_i   (wr0_en),
    .idx_i  (wr0_idx),
    .mode_i (wr0_mode),
    .phys_o (w0_phys),
    .hit_o  (w0_hit)
  );

  reg_bank_map #(.DROP_BAD_MODE(1'b1)) u_map_wr1 (
    .en_i   (wr1_en),
    .idx_i  (wr1_idx),
    .mode_i (wr1_mode),
    .phys_o (w1_phys),
    .hit_o  (w1_hit)
  );

  // wr0 wins a same-slot collision, so wr1 is discarded for both storage and bypass
  assign w1_eff = w1_hit && !(w0_hit && (w0_phys == w1_phys));

  // Read ports: array contents, overridden by a same-cycle write outside reset
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      rd_data[p] = '0;
      if (rd_hit[p]) begin
        rd_data[p] = regs_q[rd_phys[p]];
        if (!rst && w0_hit && (rd_phys[p] == w0_phys)) begin
          rd_data[p] = wr0_data;
        end else if (!rst && w1_eff && (rd_phys[p] == w1_phys)) begin
          rd_data[p] = wr1_data;
        end
      end
    end
  end

  assign rdata_0 = rd_data[0];
  assign rdata_1 = rd_data[1];
  assign rdata_2 = rd_data[2];

  // SPSR: merge enabled byte lanes into the target bank and bypass to the read side
  always_comb begin
    wsel          = spsr_sel(spsr_wmode);
    rsel          = spsr_sel(rd_mode);
    spsr_wr_en    = !rst && wsel.valid && (spsr_we != 4'b0000);
    spsr_merged_d = spsr_q[wsel.idx];
    for (int unsigned k = 0; k < 4; k++) begin
      if (spsr_we[k]) begin
        spsr_merged_d[8*k +: 8] = spsr_wdata[8*k +: 8];
      end
    end
    spsr_out = '0;
    if (rsel.valid) begin
      spsr_out = (spsr_wr_en && (wsel.idx == rsel.idx)) ? spsr_merged_d : spsr_q[rsel.idx];
    end
  end

  // State update: reset clears everything and overrides all writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      for (int unsigned i = 0; i < NUM_SPSR; i++) spsr_q[i] <= '0;
    end else begin
      if (w1_eff)     regs_q[w1_phys]  <= wr1_data;
      if (w0_hit)     regs_q[w0_phys]  <= wr0_data;
      if (spsr_wr_en) spsr_q[wsel.idx] <= spsr_merged_d;
    end
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: read_0/read_1/read_2  in  4 each  architectural register index requested by decode.
REQ-004 SHALL have ports: rdata_0/rdata_1/rdata_2  out  32 each  combinational read data.
REQ-005 SHALL have port: rd_mode  in  5  CPSR[4:0] of decode stage; selects read bank.
REQ-006 SHALL have ports: wr0_en in 1, wr0_idx in 4, wr0_data in 32, wr0_mode in 5  write port 0 (ALU result).
REQ-007 SHALL have ports: wr1_en in 1, wr1_idx in 4, wr1_data in 32, wr1_mode in 5  write port 1 (load data / base writeback).
REQ-008 SHALL have port: spsr_out  out  32  SPSR of rd_mode bank, combinational.
REQ-009 SHALL have ports: spsr_we in 4 (byte-lane mask), spsr_wdata in 32, spsr_wmode in 5  SPSR write.

Function
REQ-010 SHALL hold 30 physical registers: r0-r7 shared; r8-r12 usr and fiq banks; r13-r14 for usr/sys, fiq, irq, svc, abt, und.
REQ-011 SHALL hold 5 SPSRs: fiq, irq, svc, abt, und.
REQ-012 SHALL map (index, mode) to physical register per ARM banking; sys uses usr bank.
REQ-013 SHALL map an unrecognised mode encoding to the usr bank for reads; writes with unrecognised mode SHALL be dropped.
REQ-014 SHALL return 32'h0 for any read of index 15; writes to index 15 SHALL be ignored (PC owned by decode/fetch).
REQ-015 SHALL latch an enabled write at the rising edge; data visible in array next cycle.
REQ-016 SHALL bypass: a read whose (read_n, rd_mode) maps to the same physical register as an enabled same-cycle write SHALL return that write's data.
REQ-017 SHALL, when wr0 and wr1 hit the same physical register in one cycle, store wr0_data and bypass wr0_data; wr1 discarded.
REQ-018 SHALL, when wr0 and wr1 hit different physical registers, perform both writes.
REQ-019 SHALL update SPSR byte lane k (bits 8k+7:8k) only where spsr_we[k]=1, into the bank of spsr_wmode.
REQ-020 SHALL drop SPSR writes when spsr_wmode is usr, sys or unrecognised; spsr_out SHALL read 32'h0 in those modes.
REQ-021 SHALL bypass SPSR: same-cycle write to rd_mode's SPSR appears on spsr_out with masked lanes merged.
REQ-022 SHALL have zero read latency and one-cycle write latency; no stall or handshake outputs.

Reset
REQ-023 SHALL clear all 30 registers and 5 SPSRs to 32'h0 on a clk edge with rst=1.
REQ-024 SHALL ignore all write ports on a cycle with rst=1 (reset wins over any write).
REQ-025 SHALL disable bypass while rst=1; rdata and spsr_out reflect array contents only.

Structure
REQ-026 SHALL take CPSR mode encodings (usr, fiq, irq, svc, abt, und, sys) and CPSR field positions from the shared ARM_Constants include; no local literal mode values.
REQ-027 SHALL implement (index, mode) -> physical index mapping as one combinational sub-module, reg_bank_map, instantiated per read and write port (5 instances).
REQ-028 SHALL hold registers as a 30-entry by 32-bit array and SPSRs as a 5-entry by 32-bit array.

Verification
REQ-029 Bench SHALL: reset, then read r0-r14 all modes -> all 32'h0; spsr_out 32'h0.
REQ-030 Bench SHALL: write r13=32'hAAAA0001 in svc, r13=32'hBBBB0002 in irq; read r13 in svc/irq/usr -> 32'hAAAA0001 / 32'hBBBB0002 / 32'h0.
REQ-031 Bench SHALL: fiq write r9=32'h12345678; usr read r9 -> 32'h0; fiq read r9 -> 32'h12345678; usr write r3=5 read in fiq -> 5.
REQ-032 Bench SHALL: wr0 r4=32'h11, wr1 r4=32'h22 same cycle, read_0=4 same cycle -> rdata_0 32'h11; next cycle 32'h11.
REQ-033 Bench SHALL: svc SPSR=32'hFFFFFFFF, then spsr_we=4'b1000 wdata=32'h600000D3 -> spsr_out 32'h60FFFFFF; same write in usr -> no change.
REQ-034 Bench SHALL: rst=1 with wr0_en=1 r1=32'h99 -> r1 reads 32'h0 after edge, rdata_0 shows no bypass during reset.
